// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and its ALU.
// Holds FSM state codes, instruction opcodes and ALU operation codes.
// Opcode-class helpers keep the decode rules in one place.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction opcodes (memory read data [15:12])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation codes; R-type and BNE pass their opcode straight through
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_NE  = 4'b1010;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_rtype(op) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BNE) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts consecutive not-ready cycles of a memory access.
// timeout is combinational, high in the WAIT_MAX-th consecutive stalled cycle.
// The count is zero whenever no access is stalled, so every access starts at 0.
module multicycle_ctrl_mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  assign timeout = waiting && !mem_ready && (cnt == CW'(WAIT_MAX - 1));

  // Count stalled cycles; any completion or leaving FETCH/MEM rearms the count
  always_ff @(posedge clk) begin
    if (clear || !waiting || mem_ready) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with retire counter.
// Moore decode from state and latched op; BNE 3, ALU/SW 4, LW 5 cycles at zero wait.
// Memory stalls hold FETCH/MEM; WAIT_MAX stalled cycles set mem_err and halt.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  mem_opcode,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err,
  output logic [15:0] retired
);

  state_t      cur;
  state_t      nxt;
  logic [3:0]  op;
  logic [15:0] retired_q;
  logic        mem_err_q;
  logic        latch_op;
  logic        retire;
  logic        set_err;
  logic        waiting;
  logic        timeout;

  assign waiting = (cur == FETCH) || (cur == MEM);

  multicycle_ctrl_mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait (
    .clk      (clk),
    .clear    (clear),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Debug state shows FETCH while clear is held, matching where the FSM lands
  assign state   = clear ? FETCH : cur;
  assign mem_err = mem_err_q;
  assign retired = retired_q;

  // Next-state and strobe decode; clear masks every strobe and side effect
  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal    = 1'b0;
    latch_op   = 1'b0;
    retire     = 1'b0;
    set_err    = 1'b0;

    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          latch_op = 1'b1;
          nxt      = DECODE;
        end else if (timeout) begin
          set_err = 1'b1;
          nxt     = HALT;
        end
      end
      DECODE: begin
        if (op == OP_HALT) begin
          nxt = HALT;
        end else if (!is_legal(op)) begin
          // Illegal ops retire as no-ops so the retire count tracks fetches
          illegal = 1'b1;
          retire  = 1'b1;
          nxt     = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (op == OP_BNE) begin
          alu_op   = op;
          pc_write = ~eq;
          pc_src   = 1'b1;
          retire   = 1'b1;
          nxt      = FETCH;
        end else if (is_rtype(op)) begin
          alu_op = op;
          nxt    = WB;
        end else begin
          // ADDI/LW/SW all add the immediate to the base register
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
          nxt     = (op == OP_ADDI) ? WB : MEM;
        end
      end
      MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op == OP_LW);
        mem_write = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_LW) begin
            nxt = WB;
          end else begin
            retire = 1'b1;
            nxt    = FETCH;
          end
        end else if (timeout) begin
          set_err = 1'b1;
          nxt     = HALT;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype(op);
        mem_to_reg = (op == OP_LW);
        retire     = 1'b1;
        nxt        = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt = FETCH;
      end
    endcase

    if (clear) begin
      nxt        = FETCH;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = ALU_ADD;
      halted     = 1'b0;
      illegal    = 1'b0;
      latch_op   = 1'b0;
      retire     = 1'b0;
      set_err    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      cur <= FETCH;
    end else begin
      cur <= nxt;
    end
  end

  // Opcode latch, retire counter (wraps silently) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (clear) begin
      op        <= OP_ADD;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (latch_op) op <= mem_opcode;
      if (retire) retired_q <= retired_q + 16'd1;
      if (set_err) mem_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum memory wait cycles per access before error.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 mem_opcode  input  4  memory read data [15:12]; sampled only in FETCH on mem_ready.
REQ-005 eq  input  1  ALU equality flag, valid in EXEC.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write  output  1 each  PC/IR/memory strobes; pc_src 0=PC+1, 1=branch target; i_or_d 0=PC address, 1=ALUresult address.
REQ-008 reg_dst, reg_write, alu_src, mem_to_reg  output  1 each  register-file/ALU mux controls; reg_dst 1=Caddr.
REQ-009 alu_op  output  4  ALU operation code.
REQ-010 state  output  3  current FSM state code, for debug.
REQ-011 halted, illegal, mem_err  output  1 each  status: halted level, illegal-op one-cycle pulse, memory-timeout sticky flag.
REQ-012 retired  output  16  count of completed instructions.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs decoded from state and internal op register (Moore), none from mem_opcode.
REQ-014 FETCH: mem_read=1, i_or_d=0; hold while mem_ready=0; on mem_ready=1 assert ir_write=1, pc_write=1, pc_src=0, latch mem_opcode into op, go DECODE.
REQ-015 DECODE: one cycle, all strobes 0; HALT op (1111) -> HALT; illegal op -> pulse illegal, go FETCH, no writes, retired+1; else -> EXEC.
REQ-016 Opcodes: R-type ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100; ADDI 0101; LW 1000; SW 1001; BNE 1010; HALT 1111; all others illegal.
REQ-017 EXEC: alu_op=op for R-type/BNE, alu_op=ADD (0000) for ADDI/LW/SW; alu_src=1 for ADDI/LW/SW, else 0; R-type/ADDI -> WB; LW/SW -> MEM.
REQ-018 EXEC BNE: pc_write=~eq, pc_src=1, retired+1, -> FETCH.
REQ-019 MEM: i_or_d=1; mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready=1; then LW -> WB, SW -> FETCH with retired+1.
REQ-020 WB: reg_write=1 for exactly one cycle; reg_dst=1 for R-type, 0 for ADDI/LW; mem_to_reg=1 only for LW; retired+1; -> FETCH.
REQ-021 Zero-wait latency: BNE 3 cycles, R-type/ADDI/SW 4, LW 5, HALT 2 to enter HALT.
REQ-022 Wait counter SHALL reset on each FETCH/MEM entry; if mem_ready stays 0 for WAIT_MAX consecutive cycles, set mem_err and go HALT.
REQ-023 HALT: all strobes 0, halted=1; leaves only on clear.
REQ-024 retired SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-025 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-026 At most one of mem_read/mem_write high in any cycle; pc_write and reg_write never both high.

Reset
REQ-027 clear=1 at any edge, including mid-MEM wait, SHALL force FETCH, op=0000, retired=0, wait counter=0, mem_err=0, halted=0, illegal=0; a pending SW is abandoned.
REQ-028 While clear=1, all strobes SHALL be 0 (clear overrides FETCH decode); state=FETCH code 3'd0.

Structure
REQ-029 Opcode constants, state encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5) and ALU op codes SHALL live in a shared package used by the ALU and this controller.
REQ-030 One sub-module SHALL be natural: mem_wait_timer (wait counter plus timeout compare), instantiated once.

Verification
REQ-031 ADD (0000), mem_ready tied 1 -> FETCH,DECODE,EXEC,WB; reg_write=1,reg_dst=1 only in cycle 4; retired 0->1.
REQ-032 LW (1000), mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-033 BNE with eq=0 -> pc_write=1,pc_src=1 in EXEC; eq=1 -> pc_write=0; both 3 cycles.
REQ-034 Opcode 0110 -> illegal pulse one cycle in DECODE, no reg_write/mem_write, next FETCH on cycle 3.
REQ-035 mem_ready held 0 in FETCH, WAIT_MAX=15 -> mem_err=1, halted=1 after 15 cycles; clear -> state 0, flags 0.
REQ-036 clear asserted in SW MEM wait -> next cycle mem_write=0, state=FETCH, retired=0.
